// File: rtl/path_sequencer_pkg.sv
// Shared state encoding and behaviour codes for the path sequencer.
// The SPI/message-interpreter side imports the same codes for host decoding.
package path_sequencer_pkg;

    localparam int unsigned PATH_WIDTH = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_MOVE    = 3'd2,
        ST_DWELL   = 3'd3,
        ST_DONE    = 3'd4,
        ST_STOPPED = 3'd5
    } seqState_t;

    localparam logic [7:0] BHV_IDLE    = 8'h00;
    localparam logic [7:0] BHV_LOAD    = 8'h01;
    localparam logic [7:0] BHV_MOVE    = 8'h02;
    localparam logic [7:0] BHV_DWELL   = 8'h03;
    localparam logic [7:0] BHV_DONE    = 8'h04;
    localparam logic [7:0] BHV_STOPPED = 8'h05;

    function automatic logic [7:0] behaviorCode(input seqState_t s);
        case (s)
            ST_IDLE:    return BHV_IDLE;
            ST_LOAD:    return BHV_LOAD;
            ST_MOVE:    return BHV_MOVE;
            ST_DWELL:   return BHV_DWELL;
            ST_DONE:    return BHV_DONE;
            ST_STOPPED: return BHV_STOPPED;
            default:    return BHV_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/path_sequencer_if.sv
// Command/status bundle between the host-side command block and the sequencer.
interface path_sequencer_if #(
    parameter int unsigned INT_WIDTH = 8,
    parameter int unsigned WP_WIDTH  = 2
);
    import path_sequencer_pkg::*;

    logic [PATH_WIDTH-1:0] PATH_SEQUENCER_WAYSELECT_InBus;
    logic                  PATH_SEQUENCER_BEGINSIGNAL_InLow;
    logic                  PATH_SEQUENCER_STOPSIGNAL_InLow;
    logic                  PATH_SEQUENCER_ARRIVED_In;
    logic [PATH_WIDTH-1:0] PATH_SEQUENCER_PATH_OutBus;
    logic [WP_WIDTH-1:0]   PATH_SEQUENCER_WAYPOINT_OutBus;
    logic                  PATH_SEQUENCER_LOADWP_Out;
    logic                  PATH_SEQUENCER_RUN_Out;
    logic [INT_WIDTH-1:0]  PATH_SEQUENCER_BEHAVIOR_OutBus;

    modport master (
        output PATH_SEQUENCER_WAYSELECT_InBus, PATH_SEQUENCER_BEGINSIGNAL_InLow,
               PATH_SEQUENCER_STOPSIGNAL_InLow, PATH_SEQUENCER_ARRIVED_In,
        input  PATH_SEQUENCER_PATH_OutBus, PATH_SEQUENCER_WAYPOINT_OutBus,
               PATH_SEQUENCER_LOADWP_Out, PATH_SEQUENCER_RUN_Out,
               PATH_SEQUENCER_BEHAVIOR_OutBus
    );

    modport slave (
        input  PATH_SEQUENCER_WAYSELECT_InBus, PATH_SEQUENCER_BEGINSIGNAL_InLow,
               PATH_SEQUENCER_STOPSIGNAL_InLow, PATH_SEQUENCER_ARRIVED_In,
        output PATH_SEQUENCER_PATH_OutBus, PATH_SEQUENCER_WAYPOINT_OutBus,
               PATH_SEQUENCER_LOADWP_Out, PATH_SEQUENCER_RUN_Out,
               PATH_SEQUENCER_BEHAVIOR_OutBus
    );

endinterface

// File: rtl/path_sequencer_dwell_timer.sv
// Settle timer: counts enabled cycles from a clear; done on the last dwell cycle.
module dwell_timer #(
    parameter int unsigned SETTLE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int unsigned CNT_WIDTH = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(SETTLE_CYCLES - 1);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign done = enable && (count == LAST_COUNT);

endmodule

// File: rtl/path_sequencer.sv
// Waypoint sequencer: load, move, dwell per waypoint of the host-selected path,
// with stop/resume and an 8-bit behaviour code for host readback.
module path_sequencer
    import path_sequencer_pkg::*;
#(
    parameter int unsigned INT_WIDTH     = 8,
    parameter int unsigned WAYPOINTS     = 4,
    parameter int unsigned WP_WIDTH      = 2,
    parameter int unsigned SETTLE_CYCLES = 50000
) (
    input logic             PATH_SEQUENCER_CLOCK_50,
    input logic             PATH_SEQUENCER_RESET_InLow,
    path_sequencer_if.slave bus
);
    localparam logic [WP_WIDTH-1:0] LAST_WP = WP_WIDTH'(WAYPOINTS - 1);

    seqState_t             state;
    logic [PATH_WIDTH-1:0] pathReg;
    logic [WP_WIDTH-1:0]   waypointReg;
    logic                  loadWpReg;
    logic                  runReg;
    logic [INT_WIDTH-1:0]  behaviorReg;
    logic                  beginPrev;
    logic                  beginEvent;
    logic                  dwellDone;

    function automatic logic [INT_WIDTH-1:0] codeOf(input seqState_t s);
        return INT_WIDTH'(behaviorCode(s));
    endfunction

    // beginPrev resets low so a begin held through reset is not an event
    assign beginEvent = beginPrev && !bus.PATH_SEQUENCER_BEGINSIGNAL_InLow;

    dwell_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) uDwellTimer (
        .clk    (PATH_SEQUENCER_CLOCK_50),
        .rstN   (PATH_SEQUENCER_RESET_InLow),
        .clear  (state != ST_DWELL),
        .enable (state == ST_DWELL),
        .done   (dwellDone)
    );

    always_ff @(posedge PATH_SEQUENCER_CLOCK_50 or negedge PATH_SEQUENCER_RESET_InLow) begin
        if (!PATH_SEQUENCER_RESET_InLow) begin
            state       <= ST_IDLE;
            pathReg     <= '0;
            waypointReg <= '0;
            loadWpReg   <= 1'b0;
            runReg      <= 1'b0;
            behaviorReg <= '0;
            beginPrev   <= 1'b0;
        end else begin
            beginPrev <= bus.PATH_SEQUENCER_BEGINSIGNAL_InLow;
            loadWpReg <= 1'b0;
            if (!bus.PATH_SEQUENCER_STOPSIGNAL_InLow) begin
                state       <= ST_STOPPED;
                runReg      <= 1'b0;
                behaviorReg <= codeOf(ST_STOPPED);
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (beginEvent && bus.PATH_SEQUENCER_WAYSELECT_InBus != '0) begin
                            pathReg     <= bus.PATH_SEQUENCER_WAYSELECT_InBus;
                            waypointReg <= '0;
                            state       <= ST_LOAD;
                            loadWpReg   <= 1'b1;
                            behaviorReg <= codeOf(ST_LOAD);
                        end
                    end
                    ST_LOAD: begin
                        state       <= ST_MOVE;
                        runReg      <= 1'b1;
                        behaviorReg <= codeOf(ST_MOVE);
                    end
                    ST_MOVE: begin
                        if (bus.PATH_SEQUENCER_ARRIVED_In) begin
                            state       <= ST_DWELL;
                            runReg      <= 1'b0;
                            behaviorReg <= codeOf(ST_DWELL);
                        end
                    end
                    ST_DWELL: begin
                        if (dwellDone) begin
                            if (waypointReg == LAST_WP) begin
                                state       <= ST_DONE;
                                behaviorReg <= codeOf(ST_DONE);
                            end else begin
                                waypointReg <= waypointReg + 1'b1;
                                state       <= ST_LOAD;
                                loadWpReg   <= 1'b1;
                                behaviorReg <= codeOf(ST_LOAD);
                            end
                        end
                    end
                    // resume uses the retained path/waypoint; WAYSELECT is not re-sampled
                    ST_STOPPED: begin
                        if (beginEvent) begin
                            state       <= ST_LOAD;
                            loadWpReg   <= 1'b1;
                            behaviorReg <= codeOf(ST_LOAD);
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        runReg      <= 1'b0;
                        behaviorReg <= codeOf(ST_IDLE);
                    end
                endcase
            end
        end
    end

    assign bus.PATH_SEQUENCER_PATH_OutBus     = pathReg;
    assign bus.PATH_SEQUENCER_WAYPOINT_OutBus = waypointReg;
    assign bus.PATH_SEQUENCER_LOADWP_Out      = loadWpReg;
    assign bus.PATH_SEQUENCER_RUN_Out         = runReg;
    assign bus.PATH_SEQUENCER_BEHAVIOR_OutBus = behaviorReg;

endmodule

// File: tb/tb_path_sequencer.sv
// Randomized bench for path_sequencer: per-run expected output timelines are built
// from the phase lengths (load 1, move until arrival, dwell SETTLE) and compared cycle by cycle.
module tb_path_sequencer;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned NWP    = 4;

    typedef struct {
        logic [7:0] bhv;
        logic       run;
        logic       load;
        logic [1:0] wp;
        logic       arr;
        logic       beg;
        logic [2:0] ws;
    } obs_t;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    path_sequencer_if #(.INT_WIDTH(8), .WP_WIDTH(2)) bus ();

    path_sequencer #(
        .INT_WIDTH(8), .WAYPOINTS(NWP), .WP_WIDTH(2), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .PATH_SEQUENCER_CLOCK_50    (clk),
        .PATH_SEQUENCER_RESET_InLow (rstN),
        .bus                        (bus)
    );

    obs_t        plan[$];
    logic [14:0] seen[$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t mk(input logic [7:0] b, input logic r, input logic l,
                                input int w, input logic a, input logic g);
        obs_t o;
        o.bhv = b; o.run = r; o.load = l; o.wp = 2'(w); o.arr = a; o.beg = g;
        o.ws = 3'($urandom_range(0, 7));
        return o;
    endfunction

    function automatic logic [14:0] expOf(input obs_t e, input logic [2:0] p);
        return {e.bhv, e.run, e.load, e.wp, p};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.PATH_SEQUENCER_BEHAVIOR_OutBus, bus.PATH_SEQUENCER_RUN_Out,
                bus.PATH_SEQUENCER_LOADWP_Out, bus.PATH_SEQUENCER_WAYPOINT_OutBus,
                bus.PATH_SEQUENCER_PATH_OutBus};
    endfunction

    function automatic string fmt(input logic [14:0] v);
        return $sformatf("bhv=%02h run=%0b load=%0b wp=%0d path=%0d",
                         v[14:7], v[6], v[5], v[4:3], v[2:0]);
    endfunction

    function automatic int findObs(input logic [7:0] b, input int w);
        foreach (plan[i]) if (plan[i].bhv == b && plan[i].wp == 2'(w)) return i;
        return 0;
    endfunction

    // Expected timeline from startWp to DONE; arrival raised on a random MOVE cycle.
    task automatic buildPlan(input int startWp);
        int m;
        plan.delete();
        for (int w = startWp; w < int'(NWP); w++) begin
            m = int'($urandom_range(1, 3));
            plan.push_back(mk(8'h01, 1'b0, 1'b1, w, rb(), rb()));
            for (int j = 0; j < m; j++) plan.push_back(mk(8'h02, 1'b1, 1'b0, w, j == m - 1, rb()));
            for (int j = 0; j < int'(SETTLE); j++) plan.push_back(mk(8'h03, 1'b0, 1'b0, w, rb(), rb()));
        end
        repeat (3) plan.push_back(mk(8'h04, 1'b0, 1'b0, int'(NWP) - 1, rb(), 1'b1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b1;
        bus.PATH_SEQUENCER_STOPSIGNAL_InLow  = 1'b1;
        bus.PATH_SEQUENCER_ARRIVED_In        = 1'b0;
        bus.PATH_SEQUENCER_WAYSELECT_InBus   = 3'd0;
        step(); step();
        rstN = 1'b1;
        step();
    endtask

    task automatic driveBegin(input logic [2:0] ws);
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b1;
        step();
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b0;
        bus.PATH_SEQUENCER_WAYSELECT_InBus   = ws;
        step();
    endtask

    task automatic runPlan(input int count);
        seen.delete();
        for (int t = 0; t < count; t++) begin
            seen.push_back(observed());
            bus.PATH_SEQUENCER_ARRIVED_In        = plan[t].arr;
            bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = plan[t].beg;
            bus.PATH_SEQUENCER_WAYSELECT_InBus   = plan[t].ws;
            step();
        end
        bus.PATH_SEQUENCER_ARRIVED_In        = 1'b0;
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b1;
        bus.PATH_SEQUENCER_STOPSIGNAL_InLow  = 1'b1;
        bus.PATH_SEQUENCER_ARRIVED_In        = 1'b0;
        bus.PATH_SEQUENCER_WAYSELECT_InBus   = 3'd3;
        step(); step();
        vectors++;
        if (observed() !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_state got %s want %s", fmt(observed()), fmt(15'h0));
        end
        rstN = 1'b1;
        step();
        vectors++;
        if (observed() !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_release got %s want %s", fmt(observed()), fmt(15'h0));
        end
    endtask

    task automatic test_normal_run();
        logic [2:0] p;
        int loads;
        for (int r = 0; r < 3; r++) begin
            p = (r == 0) ? 3'd3 : 3'($urandom_range(1, 7));
            buildPlan(0);
            driveBegin(p);
            runPlan(plan.size());
            loads = 0;
            foreach (seen[i]) begin
                vectors++;
                loads += int'(seen[i][5]);
                if (seen[i] !== expOf(plan[i], p)) begin
                    miscompares++;
                    $display("FAIL normal_run r=%0d t=%0d got %s want %s", r, i,
                             fmt(seen[i]), fmt(expOf(plan[i], p)));
                end
            end
            vectors++;
            if (loads !== int'(NWP)) begin
                miscompares++;
                $display("FAIL normal_run_loads r=%0d got %0d want %0d", r, loads, NWP);
            end
        end
    endtask

    task automatic test_invalid_path();
        applyReset();
        driveBegin(3'd0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (observed() !== 15'h0) begin
                miscompares++;
                $display("FAIL invalid_path t=%0d got %s want %s", i, fmt(observed()), fmt(15'h0));
            end
            bus.PATH_SEQUENCER_ARRIVED_In        = rb();
            bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = rb();
            step();
        end
        bus.PATH_SEQUENCER_ARRIVED_In = 1'b0;
    endtask

    task automatic test_stop_resume();
        logic [2:0] p;
        int idx;
        logic [14:0] want;
        applyReset();
        do p = 3'($urandom_range(1, 7)); while (p == 3'd5);
        buildPlan(0);
        idx = findObs(8'h02, 2);
        driveBegin(p);
        runPlan(idx);
        foreach (seen[i]) begin
            vectors++;
            if (seen[i] !== expOf(plan[i], p)) begin
                miscompares++;
                $display("FAIL stop_prefix t=%0d got %s want %s", i, fmt(seen[i]), fmt(expOf(plan[i], p)));
            end
        end
        bus.PATH_SEQUENCER_STOPSIGNAL_InLow = 1'b0;
        step();
        want = {8'h05, 1'b0, 1'b0, 2'd2, p};
        vectors++;
        if (observed() !== want) begin
            miscompares++;
            $display("FAIL stop_entry got %s want %s", fmt(observed()), fmt(want));
        end
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b0;
        bus.PATH_SEQUENCER_WAYSELECT_InBus   = 3'd6;
        step();
        vectors++;
        if (observed() !== want) begin
            miscompares++;
            $display("FAIL stop_begin_ignored got %s want %s", fmt(observed()), fmt(want));
        end
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b1;
        step();
        bus.PATH_SEQUENCER_STOPSIGNAL_InLow = 1'b1;
        step();
        vectors++;
        if (observed() !== want) begin
            miscompares++;
            $display("FAIL stop_release_hold got %s want %s", fmt(observed()), fmt(want));
        end
        buildPlan(2);
        driveBegin(3'd5);
        runPlan(plan.size());
        foreach (seen[i]) begin
            vectors++;
            if (seen[i] !== expOf(plan[i], p)) begin
                miscompares++;
                $display("FAIL resume t=%0d got %s want %s", i, fmt(seen[i]), fmt(expOf(plan[i], p)));
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] p;
        int idx;
        logic [14:0] want;
        applyReset();
        p = 3'($urandom_range(1, 7));
        buildPlan(0);
        idx = findObs(8'h02, 1);
        driveBegin(p);
        runPlan(idx);
        foreach (seen[i]) begin
            vectors++;
            if (seen[i] !== expOf(plan[i], p)) begin
                miscompares++;
                $display("FAIL simul_prefix t=%0d got %s want %s", i, fmt(seen[i]), fmt(expOf(plan[i], p)));
            end
        end
        bus.PATH_SEQUENCER_STOPSIGNAL_InLow = 1'b0;
        bus.PATH_SEQUENCER_ARRIVED_In       = 1'b1;
        step();
        want = {8'h05, 1'b0, 1'b0, 2'd1, p};
        bus.PATH_SEQUENCER_ARRIVED_In = 1'b0;
        vectors++;
        if (observed() !== want) begin
            miscompares++;
            $display("FAIL simul_stop_arrived got %s want %s", fmt(observed()), fmt(want));
        end
        step();
        vectors++;
        if (observed() !== want) begin
            miscompares++;
            $display("FAIL simul_stop_hold got %s want %s", fmt(observed()), fmt(want));
        end
        bus.PATH_SEQUENCER_STOPSIGNAL_InLow = 1'b1;
        buildPlan(1);
        driveBegin(3'($urandom_range(0, 7)));
        runPlan(plan.size());
        foreach (seen[i]) begin
            vectors++;
            if (seen[i] !== expOf(plan[i], p)) begin
                miscompares++;
                $display("FAIL simul_resume t=%0d got %s want %s", i, fmt(seen[i]), fmt(expOf(plan[i], p)));
            end
        end
    endtask

    task automatic test_held_begin();
        logic [14:0] want;
        rstN = 1'b0;
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b0;
        bus.PATH_SEQUENCER_WAYSELECT_InBus   = 3'd3;
        step(); step();
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (observed() !== 15'h0) begin
                miscompares++;
                $display("FAIL held_begin t=%0d got %s want %s", i, fmt(observed()), fmt(15'h0));
            end
        end
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b1;
        step();
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b0;
        step();
        want = {8'h01, 1'b0, 1'b1, 2'd0, 3'd3};
        vectors++;
        if (observed() !== want) begin
            miscompares++;
            $display("FAIL held_begin_reassert got %s want %s", fmt(observed()), fmt(want));
        end
        bus.PATH_SEQUENCER_BEGINSIGNAL_InLow = 1'b1;
    endtask

    task automatic test_reset_mid_dwell();
        logic [2:0] p;
        int idx;
        applyReset();
        p = 3'($urandom_range(1, 7));
        buildPlan(0);
        idx = findObs(8'h03, 1) + int'($urandom_range(0, SETTLE - 1));
        driveBegin(p);
        runPlan(idx);
        vectors++;
        if (observed() !== expOf(plan[idx], p)) begin
            miscompares++;
            $display("FAIL mid_dwell_pre got %s want %s", fmt(observed()), fmt(expOf(plan[idx], p)));
        end
        #2 rstN = 1'b0;
        #1;
        vectors++;
        if (observed() !== 15'h0) begin
            miscompares++;
            $display("FAIL async_reset got %s want %s", fmt(observed()), fmt(15'h0));
        end
        step();
        rstN = 1'b1;
        p = 3'($urandom_range(1, 7));
        buildPlan(0);
        driveBegin(p);
        runPlan(plan.size());
        foreach (seen[i]) begin
            vectors++;
            if (seen[i] !== expOf(plan[i], p)) begin
                miscompares++;
                $display("FAIL post_reset_run t=%0d got %s want %s", i, fmt(seen[i]), fmt(expOf(plan[i], p)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_normal_run();
        test_invalid_path();
        test_stop_resume();
        test_simultaneous();
        test_held_begin();
        test_reset_mid_dwell();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
